// File: rtl/clock_divider_bank.sv
`default_nettype none
// ============================================================================
// Module   : clock_divider_bank
// Brief    : NUM_CH independent programmable clock dividers on one system
//            clock. Each channel has a registered, glitch-free divided clock
//            and a one-cycle wrap tick. New divisor/high-time settings enter
//            through a valid/ready port and take effect at a period boundary.
// Options  : CLKDIV_PHASE_SYNC_EN - adds a 'sync' input that phase-aligns
//            all enabled channels and applies pending settings at once.
// Revision : 1.0 - initial release
// ============================================================================
module clock_divider_bank #(
    parameter int NUM_CH      = 4,
    parameter int DIV_WIDTH   = 16,
    parameter int DEFAULT_DIV = 50
) (
    input  logic                                              clk,
    input  logic                                              reset,
    input  logic [NUM_CH-1:0]                                 en,
`ifdef CLKDIV_PHASE_SYNC_EN
    input  logic                                              sync,
`endif
    input  logic                                              cfg_valid,
    output logic                                              cfg_ready,
    input  logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0]    cfg_ch,
    input  logic [DIV_WIDTH-1:0]                              cfg_div,
    input  logic [DIV_WIDTH-1:0]                              cfg_high,
    output logic [NUM_CH-1:0]                                 outClk,
    output logic [NUM_CH-1:0]                                 tick
);

    localparam int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int CH_SPAN = 1 << CH_W;

    localparam logic [DIV_WIDTH-1:0] C_DEF_DIV  = DIV_WIDTH'(DEFAULT_DIV);
    localparam logic [DIV_WIDTH-1:0] C_DEF_HIGH = C_DEF_DIV >> 1;
    localparam logic [DIV_WIDTH-1:0] C_ONE      = DIV_WIDTH'(1);
    localparam logic [DIV_WIDTH-1:0] C_TWO      = DIV_WIDTH'(2);

    logic [NUM_CH-1:0]    w_pending;
    logic [CH_SPAN-1:0]   w_pending_ext;
    logic [DIV_WIDTH-1:0] w_cfg_div_cl;
    logic [DIV_WIDTH-1:0] w_cfg_high_cl;
    logic                 w_sync;

`ifdef CLKDIV_PHASE_SYNC_EN
    assign w_sync = sync;
`else
    assign w_sync = 1'b0;
`endif

    // Unused channel codes read as "not pending", so out-of-range requests
    // see ready=1 and match no channel, i.e. they are silently dropped.
    assign w_pending_ext = CH_SPAN'(w_pending);
    assign cfg_ready     = ~w_pending_ext[cfg_ch];

    // Clamp the requested divisor/high-time so D-H can never underflow.
    always_comb begin
        w_cfg_div_cl  = (cfg_div < C_TWO) ? C_TWO : cfg_div;
        w_cfg_high_cl = cfg_high;
        if ((cfg_high == '0) || (cfg_high >= w_cfg_div_cl)) begin
            w_cfg_high_cl = w_cfg_div_cl >> 1;
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic [DIV_WIDTH-1:0] r_cnt;
        logic [DIV_WIDTH-1:0] r_div;
        logic [DIV_WIDTH-1:0] r_high;
        logic [DIV_WIDTH-1:0] r_sh_div;
        logic [DIV_WIDTH-1:0] r_sh_high;
        logic                 r_pend;
        logic                 r_out;
        logic                 r_tick;

        logic [DIV_WIDTH-1:0] w_cnt_nxt;
        logic [DIV_WIDTH-1:0] w_div_nxt;
        logic [DIV_WIDTH-1:0] w_high_nxt;
        logic [DIV_WIDTH-1:0] w_sh_div_nxt;
        logic [DIV_WIDTH-1:0] w_sh_high_nxt;
        logic                 w_pend_nxt;
        logic                 w_out_nxt;
        logic                 w_tick_nxt;
        logic                 w_apply;
        logic                 w_accept;

        assign w_accept     = cfg_valid && cfg_ready && (cfg_ch == CH_W'(i));
        assign w_pending[i] = r_pend;
        assign outClk[i]    = r_out;
        assign tick[i]      = r_tick;

        // Next-state: count/wrap, shadow hand-over at boundaries, and output
        // level computed from the post-update count so the output is a flop.
        always_comb begin
            w_cnt_nxt     = r_cnt + C_ONE;
            w_tick_nxt    = 1'b0;
            w_apply       = 1'b0;
            w_div_nxt     = r_div;
            w_high_nxt    = r_high;
            w_sh_div_nxt  = r_sh_div;
            w_sh_high_nxt = r_sh_high;
            w_pend_nxt    = r_pend;

            if (!en[i]) begin
                w_cnt_nxt = '0;
                w_apply   = r_pend;
            end else if (w_sync) begin
                w_cnt_nxt = '0;
                w_apply   = r_pend;
            end else if (r_cnt == (r_div - C_ONE)) begin
                w_cnt_nxt  = '0;
                w_tick_nxt = 1'b1;
                w_apply    = r_pend;
            end

            if (w_apply) begin
                w_div_nxt  = r_sh_div;
                w_high_nxt = r_sh_high;
                w_pend_nxt = 1'b0;
            end

            // Accept only happens when nothing is pending, so it never
            // collides with the hand-over above.
            if (w_accept) begin
                if (w_sync) begin
                    w_div_nxt  = w_cfg_div_cl;
                    w_high_nxt = w_cfg_high_cl;
                end else begin
                    w_sh_div_nxt  = w_cfg_div_cl;
                    w_sh_high_nxt = w_cfg_high_cl;
                    w_pend_nxt    = 1'b1;
                end
            end

            w_out_nxt = en[i] && !w_sync && (w_cnt_nxt >= (w_div_nxt - w_high_nxt));
        end

        // Channel state register with asynchronous reset to the default divisor.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                r_cnt     <= '0;
                r_div     <= C_DEF_DIV;
                r_high    <= C_DEF_HIGH;
                r_sh_div  <= C_DEF_DIV;
                r_sh_high <= C_DEF_HIGH;
                r_pend    <= 1'b0;
                r_out     <= 1'b0;
                r_tick    <= 1'b0;
            end else begin
                r_cnt     <= w_cnt_nxt;
                r_div     <= w_div_nxt;
                r_high    <= w_high_nxt;
                r_sh_div  <= w_sh_div_nxt;
                r_sh_high <= w_sh_high_nxt;
                r_pend    <= w_pend_nxt;
                r_out     <= w_out_nxt;
                r_tick    <= w_tick_nxt;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_clock_divider_bank.sv
`default_nettype none
// ============================================================================
// Module   : tb_clock_divider_bank
// Brief    : Directed self-checking bench for clock_divider_bank; a second
//            3-channel instance covers out-of-range channel requests.
// Revision : 1.0 - initial release
// ============================================================================
module tb_clock_divider_bank;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  en = 4'b0000;
    logic        cfg_valid = 1'b0;
    logic        cfg_ready;
    logic [1:0]  cfg_ch = 2'd0;
    logic [15:0] cfg_div = 16'd0;
    logic [15:0] cfg_high = 16'd0;
    logic [3:0]  out_clk;
    logic [3:0]  tick;

    logic [2:0]  en3 = 3'b000;
    logic        cfg_valid3 = 1'b0;
    logic        cfg_ready3;
    logic [1:0]  cfg_ch3 = 2'd0;
    logic [7:0]  cfg_div3 = 8'd0;
    logic [7:0]  cfg_high3 = 8'd0;
    logic [2:0]  out_clk3;
    logic [2:0]  tick3;

`ifdef CLKDIV_PHASE_SYNC_EN
    logic        sync = 1'b0;
`endif

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    clock_divider_bank #(.NUM_CH(4), .DIV_WIDTH(16), .DEFAULT_DIV(50)) dut (
        .clk       (clk),
        .reset     (reset),
        .en        (en),
`ifdef CLKDIV_PHASE_SYNC_EN
        .sync      (sync),
`endif
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_ch    (cfg_ch),
        .cfg_div   (cfg_div),
        .cfg_high  (cfg_high),
        .outClk    (out_clk),
        .tick      (tick)
    );

    clock_divider_bank #(.NUM_CH(3), .DIV_WIDTH(8), .DEFAULT_DIV(4)) dut3 (
        .clk       (clk),
        .reset     (reset),
        .en        (en3),
`ifdef CLKDIV_PHASE_SYNC_EN
        .sync      (sync),
`endif
        .cfg_valid (cfg_valid3),
        .cfg_ready (cfg_ready3),
        .cfg_ch    (cfg_ch3),
        .cfg_div   (cfg_div3),
        .cfg_high  (cfg_high3),
        .outClk    (out_clk3),
        .tick      (tick3)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        int d;
        int h;

        // Reset state
        step();
        step();
        check_eq("rst_out", out_clk, 4'b0000);
        check_eq("rst_tick", tick, 4'b0000);
        check_eq("rst_ready", cfg_ready, 1'b1);
        check_eq("rst_out3", out_clk3, 3'b000);

        reset = 1'b0;
        en    = 4'b0001;

        // Default 50-cycle period, then a mid-period reconfig to D=4,H=1
        for (int k = 1; k <= 166; k++) begin
            if (k == 111) begin
                cfg_ch = 2'd0; cfg_div = 16'd4; cfg_high = 16'd1; cfg_valid = 1'b1;
                #1 check_eq("t2_ready_idle", cfg_ready, 1'b1);
            end
            if (k == 112) begin
                cfg_valid = 1'b0;
                #1 check_eq("t2_ready_pend", cfg_ready, 1'b0);
            end
            if (k == 121) begin
                cfg_ch = 2'd0; cfg_div = 16'd10; cfg_high = 16'd5; cfg_valid = 1'b1;
                #1 check_eq("t3_ch0_busy", cfg_ready, 1'b0);
            end
            if (k == 122) begin
                cfg_ch = 2'd1; cfg_div = 16'd6; cfg_high = 16'd9;
                #1 check_eq("t3_ch1_ready", cfg_ready, 1'b1);
            end
            if (k == 123) begin
                cfg_valid = 1'b0;
                #1 check_eq("t3_ch1_pend", cfg_ready, 1'b0);
            end
            if (k == 124) begin
                #1 check_eq("t3_ch1_applied", cfg_ready, 1'b1);
                cfg_ch = 2'd0;
                #1 check_eq("t3_ch0_still", cfg_ready, 1'b0);
            end
            if (k == 151) begin
                #1 check_eq("t2_ready_after_wrap", cfg_ready, 1'b1);
            end
            if (k <= 150) begin
                c = k % 50; d = 50; h = 25;
            end else begin
                c = (k - 150) % 4; d = 4; h = 1;
            end
            step();
            check_eq("t12_out", out_clk, {3'b000, (c >= d - h)});
            check_eq("t12_tick", tick, {3'b000, (c == 0)});
        end

        // ch1 clamped H: D=6,H=9 -> H=3
        en = 4'b0011;
        for (int j = 1; j <= 12; j++) begin
            step();
            check_eq("t4_ch1_out", out_clk[1], ((j % 6) >= 3));
            check_eq("t4_ch1_tick", tick[1], ((j % 6) == 0));
        end

        // ch2 clamped D: D=1,H=0 -> D=2,H=1
        cfg_ch = 2'd2; cfg_div = 16'd1; cfg_high = 16'd0; cfg_valid = 1'b1;
        #1 check_eq("t4_ch2_ready", cfg_ready, 1'b1);
        step();
        cfg_valid = 1'b0;
        #1 check_eq("t4_ch2_pend", cfg_ready, 1'b0);
        step();
        check_eq("t4_ch2_applied", cfg_ready, 1'b1);
        en = 4'b0111;
        for (int j = 1; j <= 6; j++) begin
            step();
            check_eq("t4_ch2_out", out_clk[2], ((j % 2) == 1));
            check_eq("t4_ch2_tick", tick[2], ((j % 2) == 0));
        end

        // Enable drop for 3 cycles on ch1 mid-period, then restart from 0
        en = 4'b0101;
        for (int j = 1; j <= 3; j++) begin
            step();
            check_eq("t5_off_out", out_clk[1], 1'b0);
            check_eq("t5_off_tick", tick[1], 1'b0);
        end
        en = 4'b0111;
        for (int j = 1; j <= 7; j++) begin
            step();
            check_eq("t5_on_out", out_clk[1], ((j % 6) >= 3));
            check_eq("t5_on_tick", tick[1], ((j % 6) == 0));
        end

`ifdef CLKDIV_PHASE_SYNC_EN
        // Sync with a same-cycle config on ch1 (D=8,H=5) applied immediately
        en = 4'b0011;
        cfg_ch = 2'd1; cfg_div = 16'd8; cfg_high = 16'd5; cfg_valid = 1'b1; sync = 1'b1;
        step();
        cfg_valid = 1'b0; sync = 1'b0;
        #1 check_eq("t6_ready", cfg_ready, 1'b1);
        check_eq("t6_out0", out_clk[1:0], 2'b00);
        check_eq("t6_tick0", tick[1:0], 2'b00);
        for (int j = 1; j <= 16; j++) begin
            step();
            check_eq("t6_out", out_clk[1:0], {((j % 8) >= 3), ((j % 4) >= 3)});
            check_eq("t6_tick", tick[1:0], {((j % 8) == 0), ((j % 4) == 0)});
        end
        en = 4'b0101;
`endif

        // Asynchronous reset mid-period
        en = 4'b0101;
        #2 reset = 1'b1;
        #1;
        check_eq("arst_out", out_clk, 4'b0000);
        check_eq("arst_tick", tick, 4'b0000);
        check_eq("arst_ready", cfg_ready, 1'b1);
        @(negedge clk);
        reset = 1'b0;
        en3 = 3'b001;
        cfg_ch3 = 2'd3; cfg_div3 = 8'd2; cfg_high3 = 8'd1; cfg_valid3 = 1'b1;
        #1 check_eq("oor_ready", cfg_ready3, 1'b1);
        for (int j = 1; j <= 26; j++) begin
            step();
            check_eq("arst_ch0_out", out_clk[0], (j >= 25));
            check_eq("arst_ch2_out", out_clk[2], (j >= 25));
            check_eq("oor_out", out_clk3, {2'b00, ((j % 4) >= 2)});
            check_eq("oor_tick", tick3, {2'b00, ((j % 4) == 0)});
        end
        cfg_valid3 = 1'b0;

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
